// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier. It retires BPC multiplier bits per BUSY cycle
// and handles signed operands by multiplying magnitudes and negating the result.
//
// Handshake contract: a transfer happens on a rising edge where valid and ready
// are both high. in_ready depends combinationally on out_ready only, so a
// finished result can be drained and a new operation accepted on the same edge.
module seq_multiplier #(
  parameter int WIDTH = 11,
  parameter int BPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [1:0]           state_o
);

  localparam int ITER = (WIDTH + BPC - 1) / BPC;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int PW   = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [BPC-1:0]   digit;
  logic [31:0]      shamt;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_sum;
  logic             last;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = (state_q == S_BUSY);
  assign state_o   = state_q;

  // Operand magnitudes; in unsigned mode the MSB is plain data.
  assign a_neg    = in_signed & in_a[WIDTH-1];
  assign b_neg    = in_signed & in_b[WIDTH-1];
  assign mag_a_in = a_neg ? -in_a : in_a;
  assign mag_b_in = b_neg ? -in_b : in_b;

  // Partial product for the current digit. The multiplier register shifts in
  // zeros, so bits above WIDTH on a final partial digit read as zero.
  assign digit   = mplr_q[BPC-1:0];
  assign shamt   = 32'(BPC) * 32'(cnt_q);
  assign pp      = (PW'(mag_a_q) * PW'(digit)) << shamt;
  assign acc_sum = acc_q + pp;
  assign last    = (cnt_q == CW'(ITER - 1));

  // Next-state logic for the IDLE/BUSY/DONE sequencer and the datapath.
  always_comb begin
    state_d     = state_q;
    mag_a_d     = mag_a_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: ;
      S_BUSY: begin
        acc_d  = acc_sum;
        mplr_d = mplr_q >> BPC;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          product_d   = neg_q ? -acc_sum : acc_sum;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accept can only occur in IDLE or in DONE while the result drains.
    if (accept) begin
      mag_a_d = mag_a_in;
      mplr_d  = mag_b_in;
      neg_d   = a_neg ^ b_neg;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = S_BUSY;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mag_a_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_a_q     <= mag_a_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=11 with four digit sizes side by side
// (BPC = 1, 3, 4, 11). Only the selected instance sees in_valid/out_ready.
module tb_seq_multiplier;

  localparam int W = 11;

  logic          clk;
  logic          rst_n;
  logic [1:0]    sel;
  logic          in_valid;
  logic [W-1:0]  in_a, in_b;
  logic          in_signed;
  logic          out_ready;

  logic [3:0]    in_valid_v, out_ready_v;
  logic [3:0]    in_ready_v, out_valid_v, busy_v;
  logic [2*W-1:0] product_v [4];
  logic [1:0]    state_v [4];

  logic          in_ready_m, out_valid_m, busy_m;
  logic [2*W-1:0] product_m;
  logic [1:0]    state_m;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Steer handshakes to the selected instance and mux its outputs back.
  always_comb begin
    in_valid_v       = '0;
    out_ready_v      = '0;
    in_valid_v[sel]  = in_valid;
    out_ready_v[sel] = out_ready;
    in_ready_m       = in_ready_v[sel];
    out_valid_m      = out_valid_v[sel];
    busy_m           = busy_v[sel];
    product_m        = product_v[sel];
    state_m          = state_v[sel];
  end

  seq_multiplier #(.WIDTH(W), .BPC(1)) u_bpc1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .product(product_v[0]), .busy(busy_v[0]), .state_o(state_v[0]));
  seq_multiplier #(.WIDTH(W), .BPC(3)) u_bpc3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .product(product_v[1]), .busy(busy_v[1]), .state_o(state_v[1]));
  seq_multiplier #(.WIDTH(W), .BPC(4)) u_bpc4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .product(product_v[2]), .busy(busy_v[2]), .state_o(state_v[2]));
  seq_multiplier #(.WIDTH(W), .BPC(11)) u_bpc11 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid_v[3]),
    .out_ready(out_ready_v[3]), .product(product_v[3]), .busy(busy_v[3]), .state_o(state_v[3]));

  // Scoreboard helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product computed with native 64-bit arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[2*W-1:0];
  endfunction

  // Driver: one operation through the selected instance, reporting the result
  // and the number of edges from accept to out_valid.
  task automatic run_op(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sg, output logic [2*W-1:0] prod, output int lat);
    sel = s;
    @(negedge clk);
    in_a = a; in_b = b; in_signed = sg; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_signed = 1'($urandom);
    lat = 0;
    while (!out_valid_m && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = product_m;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Back-to-back random stream with random output stalls.
  task automatic stream(input logic [1:0] s);
    int sent = 0, got = 0, cyc = 0;
    logic hs_in, hs_out;
    logic [2*W-1:0] e;
    sel = s;
    in_valid = 1'b0;
    exp_q.delete();
    while (got < 100 && cyc < 20000) begin
      @(negedge clk);
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        in_a = W'($urandom); in_b = W'($urandom);
        in_signed = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      hs_in  = in_valid && in_ready_m;
      hs_out = out_valid_m && out_ready;
      @(posedge clk);
      cyc++;
      if (hs_out) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~product_m;
        check($sformatf("stream_sel%0d_item%0d", s, got), product_m, e);
        got++;
      end
      if (hs_in) begin
        exp_q.push_back(ref_mul(in_a, in_b, in_signed));
        sent++;
      end
      #1;
      if (hs_in) in_valid = 1'b0;
    end
    check($sformatf("stream_sel%0d_count", s), got, 100);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]     sel;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sg;
    logic [2*W-1:0] exp_p;
    int             exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [2*W-1:0] prod;
    int lat, bad;

    // sel: 0 -> BPC1 (11 edges), 1 -> BPC3 (4), 2 -> BPC4 (3), 3 -> BPC11 (1)
    vecs[0] = '{2'd0, 11'h7FF, 11'h7FF, 1'b0, 22'h3FF001, 11};
    vecs[1] = '{2'd2, 11'h400, 11'h400, 1'b1, 22'h100000, 3};
    vecs[2] = '{2'd0, 11'h7FF, 11'h005, 1'b1, 22'h3FFFFB, 11};
    vecs[3] = '{2'd0, 11'h7FF, 11'h005, 1'b0, 22'h0027FB, 11};
    vecs[4] = '{2'd1, 11'h000, 11'h07B, 1'b0, 22'h000000, 4};
    vecs[5] = '{2'd1, 11'h7FD, 11'h007, 1'b1, 22'h3FFFEB, 4};
    vecs[6] = '{2'd3, 11'h4D2, 11'h237, 1'b0, 22'h0AAD1E, 1};
    vecs[7] = '{2'd2, 11'h400, 11'h3FF, 1'b1, 22'h300400, 3};
    vecs[8] = '{2'd3, 11'h400, 11'h001, 1'b1, 22'h3FFC00, 1};
    vecs[9] = '{2'd1, 11'h400, 11'h7FF, 1'b1, 22'h000400, 4};

    rst_n = 1'b0; sel = 2'd0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; out_ready = 1'b0;
    #3;
    check("reset_out_valid", out_valid_m, 0);
    check("reset_product", product_m, 0);
    check("reset_busy", busy_m, 0);
    check("reset_state", state_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready_m, 1);

    // Table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sg, prod, lat);
      check($sformatf("vec%0d_product", i), prod, vecs[i].exp_p);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      drain();
      check($sformatf("vec%0d_idle_after_drain", i), in_ready_m, 1);
    end

    // Backpressure: hold the result in DONE, then consume and accept together.
    run_op(2'd0, 11'd6, 11'd7, 1'b0, prod, lat);
    check("stall_first_product", prod, 42);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check($sformatf("stall_c%0d_in_ready", c), in_ready_m, 0);
      check($sformatf("stall_c%0d_out_valid", c), out_valid_m, 1);
      check($sformatf("stall_c%0d_product", c), product_m, 42);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    in_a = 11'd3; in_b = 11'd9; in_signed = 1'b1;
    #1;
    check("stall_release_in_ready", in_ready_m, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("stall_release_busy", busy_m, 1);
    check("stall_release_out_valid", out_valid_m, 0);
    lat = 0;
    while (!out_valid_m && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("stall_second_latency", lat, 11);
    check("stall_second_product", product_m, 27);
    drain();

    // Reset in the middle of an operation leaves no stale result.
    sel = 2'd0;
    @(negedge clk);
    in_a = 11'd100; in_b = 11'd100; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid_m, 0);
    check("midreset_product", product_m, 0);
    check("midreset_busy", busy_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_in_ready", in_ready_m, 1);
    out_ready = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_m || product_m != 0) bad++;
    end
    out_ready = 1'b0;
    check("midreset_no_stale_result", bad, 0);

    // Random streams at three digit sizes
    stream(2'd0);
    stream(2'd1);
    stream(2'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
